ecp_lock_supervisor: RTL
========================

# ecp_lock_supervisor

Supervises the `locked` output of an ECP5 PLL wrapper and turns it into a clean, debounced system reset for logic clocked by the PLL outputs. Runs on the free-running board clock that feeds the PLL's CLKI, never on a PLL output. Holds `sys_rst` until lock has been continuously stable for a programmable hold time. Drives the PLL's RST input when lock is not reached within a timeout. Counts lock-loss events and PLL retries for debug.

## Interface
- `HOLD_CYCLES`, default 1024: consecutive synchronized-lock cycles required before release; must be ≥1.
- `TIMEOUT_CYCLES`, default 65536: cycles in WAIT_LOCK without lock before forcing a PLL reset; must be ≥1.
- `PLL_RST_CYCLES`, default 16: width of the `pll_rst` pulse in cycles; must be ≥1.
- `clk`  in  1  free-running reference clock, the same net as the PLL `clkin`.
- `rst`  in  1  asynchronous, active-high reset of this block.
- `locked`  in  1  PLL lock indication; asynchronous to `clk`.
- `pll_rst`  out  1  drive to the PLL RST pin; high only in PLL_RST.
- `sys_rst`  out  1  reset for the PLL-clocked domain; high in every state except RUN.
- `ready`  out  1  high only in RUN.
- `loss_count`  out  8  lock losses seen in RUN; saturates at 255.
- `retry_count`  out  4  PLL resets issued; saturates at 15.

## Operation
- **Synchronizer:** `locked` passes through 2 flops on `clk` to form `locked_s`. No other logic samples raw `locked`.
- **Cycle counter:** one shared counter, width `$clog2(max(HOLD_CYCLES, TIMEOUT_CYCLES, PLL_RST_CYCLES))+1`. It is cleared on every state change.
- **Outputs are Moore:** `sys_rst`, `ready` and `pll_rst` are decoded from the state register only.
- **Reset (`rst`=1, asynchronous):**
  - state=WAIT_LOCK, counter=0, synchronizer flops=0.
  - `sys_rst`=1, `ready`=0, `pll_rst`=0, `loss_count`=0, `retry_count`=0.
  - Asserting `rst` mid-operation (including mid-PLL_RST) returns everything to these values immediately.
- **WAIT_LOCK:**
  - If `locked_s`=1: go to STABLE.
  - Else if counter==TIMEOUT_CYCLES-1: go to PLL_RST and increment `retry_count` (saturating).
  - Otherwise: increment the counter.
- **STABLE:**
  - If `locked_s`=0: go to WAIT_LOCK (glitch rejection). The timeout restarts from 0 and `loss_count` is unchanged.
  - Else if counter==HOLD_CYCLES-1: go to RUN.
  - Otherwise: increment the counter.
- **RUN:**
  - If `locked_s`=0: go to WAIT_LOCK and increment `loss_count` (saturating at 255).
  - Otherwise: stay in RUN.
- **PLL_RST:**
  - `locked_s` is ignored.
  - When counter==PLL_RST_CYCLES-1: go to WAIT_LOCK.
  - Otherwise: increment the counter.
- **Counter saturation:** both counters hold at their maximum; they never wrap.
- **Simultaneous events:** in WAIT_LOCK, if `locked_s`=1 on the same cycle the counter reaches TIMEOUT_CYCLES-1, lock wins and the next state is STABLE with no retry.

## Timing
- Edge numbering: edge 0 is the first `clk` edge that samples a changed `locked`.
- **Lock acquisition:**
  - `locked_s` is high after edge 1.
  - The state is STABLE after edge 2.
  - The state is RUN after edge 2+HOLD_CYCLES.
  - So `ready` rises and `sys_rst` falls HOLD_CYCLES+3 edges after `locked` rises, counting edge 0.
- **Lock loss in RUN:** `sys_rst`=1 and `ready`=0 after edge 2, a 3-cycle response. `loss_count` updates on that same edge.
- **Timeout:**
  - `pll_rst` rises TIMEOUT_CYCLES edges after WAIT_LOCK is entered.
  - It stays high for exactly PLL_RST_CYCLES cycles.
  - A new timeout window then starts.
- `sys_rst` never deasserts without a full, uninterrupted HOLD_CYCLES window of `locked_s`=1.

## Test plan
All scenarios use HOLD_CYCLES=8, TIMEOUT_CYCLES=32, PLL_RST_CYCLES=4.
- **Clean lock:** release `rst`, raise `locked` at cycle 5 → `ready`=1 and `sys_rst`=0 exactly 11 edges later; `pll_rst` never asserts; both counts stay 0.
- **Glitch rejection:** `locked` high for 5 cycles, low for 1, then high → no release until 8 full synchronized cycles after the final rise; `loss_count`=0.
- **Timeout retry:** hold `locked`=0 → `pll_rst` high for 4 cycles starting 32 edges after reset; this repeats every 36 cycles; `retry_count` steps 1, 2, … and saturates at 15.
- **Lock loss:** in RUN, drop `locked` for 10 cycles → `sys_rst`=1 three edges after the drop; `loss_count`=1; re-lock releases again after HOLD_CYCLES+3 edges. Repeat 300 times → `loss_count`=255.
- **Simultaneous lock and timeout:** time `locked_s` to rise on the counter==31 cycle → next state STABLE; `retry_count` unchanged; `pll_rst` stays 0.
- **Async reset mid-PLL_RST:** assert `rst` asynchronously between clock edges → `pll_rst`=0, `sys_rst`=1 and counts=0 before the next edge.

Source files
------------

// File: rtl/ecp_lock_supervisor.sv
// ecp_lock_supervisor: turns the asynchronous PLL lock flag into a debounced
// system reset. It retries the PLL through its RST pin when lock never arrives,
// and it counts lock losses and retries for debug.
// Runs on the board reference clock that also feeds the PLL input.
module ecp_lock_supervisor #(
    parameter int unsigned HOLD_CYCLES    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned PLL_RST_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] loss_count,
    output logic [3:0] retry_count
);

    localparam int unsigned MAX_HT = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_C  = (MAX_HT > PLL_RST_CYCLES) ? MAX_HT : PLL_RST_CYCLES;
    localparam int unsigned CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] PRST_LAST    = CW'(PLL_RST_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2,
        PLL_RST   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    sync_pipe;
    logic          locked_s;
    logic          loss_inc, retry_inc;

    assign locked_s = sync_pipe[1];

    // Two-flop synchronizer. This is the only logic that samples the raw lock flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_pipe <= 2'b00;
        else     sync_pipe <= {sync_pipe[0], locked};
    end

    // State, shared cycle counter and saturating debug counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            loss_count  <= '0;
            retry_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (loss_inc && loss_count != 8'hff)  loss_count  <= loss_count + 8'd1;
            if (retry_inc && retry_count != 4'hf) retry_count <= retry_count + 4'd1;
        end
    end

    // Next state and counter. The counter restarts on every state change.
    // In WAIT_LOCK, lock is tested first, so lock beats a timeout on the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        loss_inc  = 1'b0;
        retry_inc = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    loss_inc  = 1'b1;
                end
            end
            PLL_RST: begin
                if (cnt == PRST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Moore outputs, decoded from the state register only
    always_comb begin
        pll_rst = (state == PLL_RST);
        ready   = (state == RUN);
        sys_rst = (state != RUN);
    end

endmodule
